nv_ram_rws_cfg: RTL and testbench
=================================

// Module: nv_ram_rws_cfg
// PURPOSE
//  Parametrised 1R1W synchronous RAM. Successor of the fixed-size rws RAMs.
//  Adds per-lane write mask, selectable read latency (1 or 2), read-during-write bypass,
//  a registered read-valid, and an address-sweep clear engine after reset or on request.
//  Used as a buffer RAM inside NVDLA datapath units. Has one read port and one write port.
// PARAMETERS
//  DEPTH   512  number of entries; any value >= 2, not restricted to a power of two
//  WIDTH   256  data bits per entry
//  MASK_W  32   write-mask lanes; WIDTH % MASK_W == 0; lane width LW = WIDTH/MASK_W
//  AW      9    address width; must satisfy 2**AW >= DEPTH
//  RD_LAT  1    read latency in clk edges; legal values are 1 or 2
//  BYPASS  1    1: same-address read and write in one cycle return the new data; 0: return the old data
// PORTS
//  clk            in   1       clock; all logic is on the rising edge
//  rstn           in   1       asynchronous reset, active low
//  clr            in   1       pulse: restart the clear sweep (honoured only while rdy=1)
//  rdy            out  1       1 = RAM accepts reads and writes; 0 = clear sweep in progress
//  ra             in   AW      read address
//  re             in   1       read enable
//  dout           out  WIDTH   read data; held between reads
//  dout_vld       out  1       1-cycle pulse when dout carries new read data
//  wa             in   AW      write address
//  we             in   1       write enable
//  wmask          in   MASK_W  lane i writes di[i*LW +: LW] when set
//  di             in   WIDTH   write data
//  pwrbus_ram_pd  in   32      RAM power-down bus; no functional effect; port kept for tool hookup
// BEHAVIOUR
//  Reset (rstn=0, asynchronous):
//   - dout=0, dout_vld=0, rdy=0, sweep counter cnt=0, state=INIT. The array itself has no reset.
//  FSM states INIT and RUN:
//   - INIT: on each edge, M[cnt]<=0 and cnt<=cnt+1.
//   - INIT -> RUN: the edge that writes entry DEPTH-1 also sets rdy=1.
//   - Timing: rdy rises DEPTH edges after reset release; 512 edges for the default DEPTH.
//   - RUN -> INIT: on the edge where clr=1. That edge sets cnt=0 and rdy=0.
//   - clr during INIT is ignored; the sweep is not restarted.
//   - Assertion of rstn during a sweep restarts it from entry 0.
//  Port gating:
//   - Reads and writes are qualified by rdy. Raw we and re are sampled; qualified enables are we&rdy and re&rdy.
//   - we or re while rdy=0 are dropped: no write happens, dout holds, dout_vld stays 0.
//   - An access in the same cycle as an honoured clr completes; the sweep then starts on the next edge.
//  Write: with we&rdy and wa<DEPTH, each lane i where wmask[i]=1 is updated on the edge. Other lanes keep their value.
//   - wmask=0 is a legal no-op.
//   - wa>=DEPTH: the write is dropped silently.
//  Read: with re&rdy, ra is sampled on edge N.
//   - RD_LAT=1: dout and dout_vld update at edge N. RD_LAT=2: they update at edge N+1 through an added output register.
//   - ra>=DEPTH returns all zeros with dout_vld=1.
//   - Back-to-back reads give one result per cycle. The RD_LAT=2 pipeline is not stalled by rdy=0.
//   - dout holds its last value when no read completes. dout_vld is 0 in those cycles.
//  Read-during-write at the same address, both qualified:
//   - BYPASS=1: masked lanes return di, unmasked lanes return the stored data.
//   - BYPASS=0: the pre-write content is returned.
//   - Different addresses never interact.
//  Widths: cnt is AW bits. cnt never wraps; INIT stops at DEPTH-1, including non-power-of-two DEPTH.
// TESTING (defaults unless noted)
//  1. Reset release:
//     - Stimulus: release reset, then poll rdy.
//     - Required: rdy=0 for 511 edges and 1 after edge 512.
//     - Then read all 512 addresses: every dout is 0, one dout_vld per read.
//  2. Masked write:
//     - Stimulus: wa=5, di=all 0xAA lanes, wmask=all ones. Next cycle wa=5, di=all 0x55, wmask=0x0000_0001.
//     - Required: read of 5 returns 0xAA..AA55 (lane0=0x55, other lanes 0xAA).
//  3. Read-during-write:
//     - Stimulus: we=re=1, wa=ra=7, di=0x1234, full mask, M[7]=0.
//     - Required, BYPASS=1: dout=0x1234.
//     - Required, BYPASS=0: dout=0, and a re-read returns 0x1234.
//  4. Latency:
//     - Stimulus: RD_LAT=2, reads of ra=1,2,3 on consecutive edges.
//     - Required: dout_vld high for 3 cycles, starting one edge after the RD_LAT=1 run, with data in order.
//  5. clr mid-traffic:
//     - Stimulus: write 0xFF to wa=3 in the same cycle as clr=1.
//     - Required: rdy=0 for 512 edges; we/re during that window are dropped.
//     - Required: a second clr at sweep edge 100 is ignored.
//     - Required: a read of 3 after the sweep returns 0.
//  6. Reset mid-sweep and out-of-range:
//     - Stimulus: assert rstn at sweep edge 200.
//     - Required: dout=0, dout_vld=0, rdy=0 immediately, and the sweep restarts from 0.
//     - Stimulus: DEPTH=300, AW=9, write wa=400 then read ra=400.
//     - Required: the read returns 0 with dout_vld=1.
//     - Required: no alias write; M[400-256]=M[144] is unchanged.

Source files
------------

// File: rtl/nv_ram_rws_cfg_if.sv
// ---------------------------------------------------------------------------
// nv_ram_rws_cfg_if
//   Bundles the access port of nv_ram_rws_cfg: sweep control, the read
//   port and the write port.
//   master : requester side (drives clr/ra/re/wa/we/wmask/di)
//   slave  : RAM side (drives rdy/dout/dout_vld)
// ---------------------------------------------------------------------------
interface nv_ram_rws_cfg_if #(
  parameter int AW     = 9,
  parameter int WIDTH  = 256,
  parameter int MASK_W = 32
) ();
  logic              clr;
  logic              rdy;
  logic [AW-1:0]     ra;
  logic              re;
  logic [WIDTH-1:0]  dout;
  logic              dout_vld;
  logic [AW-1:0]     wa;
  logic              we;
  logic [MASK_W-1:0] wmask;
  logic [WIDTH-1:0]  di;

  modport master (
    output clr, ra, re, wa, we, wmask, di,
    input  rdy, dout, dout_vld
  );

  modport slave (
    input  clr, ra, re, wa, we, wmask, di,
    output rdy, dout, dout_vld
  );
endinterface

// File: rtl/nv_ram_rws_cfg.sv
// ---------------------------------------------------------------------------
// nv_ram_rws_cfg
//   Parametrised 1R1W synchronous buffer RAM with per-lane write mask,
//   read latency of 1 or 2 edges, optional read-during-write bypass,
//   registered read-valid and a clear sweep that zeroes every entry after
//   reset or on a clr request.
// Ports
//   clk            rising-edge clock
//   rstn           asynchronous reset, active low
//   bus            nv_ram_rws_cfg_if.slave: clr/rdy, read port, write port
//   pwrbus_ram_pd  power-down bus, functionally unused
// ---------------------------------------------------------------------------
module nv_ram_rws_cfg #(
  parameter int DEPTH  = 512,
  parameter int WIDTH  = 256,
  parameter int MASK_W = 32,
  parameter int AW     = 9,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rstn,
  nv_ram_rws_cfg_if.slave     bus,
  input  logic [31:0]         pwrbus_ram_pd
);

  localparam int            LW       = WIDTH / MASK_W;
  localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_data;
  logic              we_en, re_en, wa_ok, ra_ok;

  logic              unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  assign we_en = bus.we & rdy_q;
  assign re_en = bus.re & rdy_q;
  assign wa_ok = {1'b0, bus.wa} < DEPTH_X;
  assign ra_ok = {1'b0, bus.ra} < DEPTH_X;

  // Sweep control: cnt stops on the last entry instead of wrapping, which
  // keeps non-power-of-two depths from running past the array.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          rdy_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  // Array has no reset; the sweep zeroes it. An access that coincides with
  // an honoured clr still lands because state is RUN on that edge.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= '0;
    end else if (we_en && wa_ok) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (bus.wmask[i]) begin
          mem[bus.wa][i*LW +: LW] <= bus.di[i*LW +: LW];
        end
      end
    end
  end

  // Out-of-range reads return zero; with bypass the masked lanes of a
  // same-address write are forwarded from di.
  always_comb begin
    rd_data = '0;
    if (ra_ok) begin
      rd_data = mem[bus.ra];
    end
    if ((BYPASS != 0) && we_en && wa_ok && ra_ok && (bus.wa == bus.ra)) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (bus.wmask[i]) begin
          rd_data[i*LW +: LW] = bus.di[i*LW +: LW];
        end
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s1_data_q, s1_data_d;
      logic             s1_vld_q, s1_vld_d;

      // Extra stage runs freely so in-flight reads finish even when rdy drops.
      always_comb begin
        s1_vld_d  = re_en;
        s1_data_d = re_en ? rd_data : s1_data_q;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s1_data_q <= '0;
          s1_vld_q  <= 1'b0;
        end else begin
          s1_data_q <= s1_data_d;
          s1_vld_q  <= s1_vld_d;
        end
      end

      always_comb begin
        dout_vld_d = s1_vld_q;
        dout_d     = s1_vld_q ? s1_data_q : dout_q;
      end
    end else begin : g_lat1
      always_comb begin
        dout_vld_d = re_en;
        dout_d     = re_en ? rd_data : dout_q;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign bus.rdy      = rdy_q;
  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;

endmodule

// File: tb/tb_nv_ram_rws_cfg.sv
// ---------------------------------------------------------------------------
// tb_nv_ram_rws_cfg
//   Directed bench for nv_ram_rws_cfg. dutA uses the default parameters
//   (DEPTH 512, RD_LAT 1, BYPASS 1); dutB uses DEPTH 300, RD_LAT 2,
//   BYPASS 0 to cover latency, old-data read-during-write and range checks.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge after the rising edge that acted on them.
// ---------------------------------------------------------------------------
module tb_nv_ram_rws_cfg;

  logic        clk;
  logic        rstn;
  logic [31:0] pwrbus;

  int compared;
  int mismatched;

  nv_ram_rws_cfg_if #(.AW(9), .WIDTH(256), .MASK_W(32)) ifA ();
  nv_ram_rws_cfg_if #(.AW(9), .WIDTH(256), .MASK_W(32)) ifB ();

  nv_ram_rws_cfg #(
    .DEPTH(512), .WIDTH(256), .MASK_W(32), .AW(9), .RD_LAT(1), .BYPASS(1)
  ) dutA (
    .clk(clk), .rstn(rstn), .bus(ifA.slave), .pwrbus_ram_pd(pwrbus)
  );

  nv_ram_rws_cfg #(
    .DEPTH(300), .WIDTH(256), .MASK_W(32), .AW(9), .RD_LAT(2), .BYPASS(0)
  ) dutB (
    .clk(clk), .rstn(rstn), .bus(ifB.slave), .pwrbus_ram_pd(pwrbus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches
  task automatic checkOutput(input string tag, input logic [255:0] got,
                             input logic [255:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one cycle on the selected port (0 = dutA, 1 = dutB), idles the
  // other port, then waits for the falling edge after the acting edge
  task automatic applyStimulus(input int sel, input logic clr, input logic we,
                               input logic [8:0] wa, input logic [31:0] wmask,
                               input logic [255:0] di, input logic re,
                               input logic [8:0] ra);
    ifA.clr = 1'b0; ifA.we = 1'b0; ifA.re = 1'b0; ifA.wa = '0; ifA.ra = '0;
    ifA.wmask = '0; ifA.di = '0;
    ifB.clr = 1'b0; ifB.we = 1'b0; ifB.re = 1'b0; ifB.wa = '0; ifB.ra = '0;
    ifB.wmask = '0; ifB.di = '0;
    if (sel == 0) begin
      ifA.clr = clr; ifA.we = we; ifA.wa = wa; ifA.wmask = wmask;
      ifA.di = di; ifA.re = re; ifA.ra = ra;
    end else begin
      ifB.clr = clr; ifB.we = we; ifB.wa = wa; ifB.wmask = wmask;
      ifB.di = di; ifB.re = re; ifB.ra = ra;
    end
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 1'b0, 1'b0, 9'd0, 32'h0, 256'h0, 1'b0, 9'd0);
  endtask

  task automatic writeWord(input int sel, input logic [8:0] wa,
                           input logic [255:0] di, input logic [31:0] wmask);
    applyStimulus(sel, 1'b0, 1'b1, wa, wmask, di, 1'b0, 9'd0);
  endtask

  task automatic readWord(input int sel, input logic [8:0] ra);
    applyStimulus(sel, 1'b0, 1'b0, 9'd0, 32'h0, 256'h0, 1'b1, ra);
  endtask

  // Directed sequence: reset sweep, masked write, bypass, latency, range,
  // clr during traffic and reset during a sweep
  initial begin
    logic [255:0] expVal;
    int n;
    int edgesA, edgesB;
    bit doneA, doneB;

    compared   = 0;
    mismatched = 0;
    pwrbus     = 32'h0;
    rstn       = 1'b0;
    ifA.clr = 1'b0; ifA.we = 1'b0; ifA.re = 1'b0; ifA.wa = '0; ifA.ra = '0;
    ifA.wmask = '0; ifA.di = '0;
    ifB.clr = 1'b0; ifB.we = 1'b0; ifB.re = 1'b0; ifB.wa = '0; ifB.ra = '0;
    ifB.wmask = '0; ifB.di = '0;

    // Reset values while rstn is low
    #12;
    checkOutput("rstA rdy", ifA.rdy, 0);
    checkOutput("rstA dout", ifA.dout, 0);
    checkOutput("rstA vld", ifA.dout_vld, 0);
    checkOutput("rstB rdy", ifB.rdy, 0);

    // Release and count edges until each RAM reports ready
    @(negedge clk);
    rstn = 1'b1;
    n = 0; doneA = 0; doneB = 0; edgesA = 0; edgesB = 0;
    while (n < 700 && !(doneA && doneB)) begin
      idleCycle();
      n++;
      if (!doneA && ifA.rdy) begin doneA = 1; edgesA = n; end
      if (!doneB && ifB.rdy) begin doneB = 1; edgesB = n; end
    end
    checkOutput("sweepA edges", 256'(edgesA), 256'd512);
    checkOutput("sweepB edges", 256'(edgesB), 256'd300);

    // Every entry of dutA reads back as zero, one valid per read
    for (int i = 0; i < 512; i++) begin
      readWord(0, 9'(i));
      checkOutput("sweepRd dout", ifA.dout, 0);
      checkOutput("sweepRd vld", ifA.dout_vld, 1);
    end
    idleCycle();
    checkOutput("sweepRd vldOff", ifA.dout_vld, 0);

    // Masked write: lane 0 overwritten, other lanes keep 0xAA
    writeWord(0, 9'd5, {32{8'hAA}}, 32'hFFFF_FFFF);
    writeWord(0, 9'd5, {32{8'h55}}, 32'h0000_0001);
    readWord(0, 9'd5);
    expVal = {32{8'hAA}};
    expVal[7:0] = 8'h55;
    checkOutput("maskWr", ifA.dout, expVal);

    // Same-address read and write with bypass returns the new data
    applyStimulus(0, 1'b0, 1'b1, 9'd7, 32'hFFFF_FFFF, 256'h1234, 1'b1, 9'd7);
    checkOutput("bypassA dout", ifA.dout, 256'h1234);
    checkOutput("bypassA vld", ifA.dout_vld, 1);

    // Partial-mask bypass: only lane 1 forwarded, rest from storage
    applyStimulus(0, 1'b0, 1'b1, 9'd5, 32'h0000_0002, {32{8'h11}}, 1'b1, 9'd5);
    expVal = {32{8'hAA}};
    expVal[7:0]  = 8'h55;
    expVal[15:8] = 8'h11;
    checkOutput("bypassA lane", ifA.dout, expVal);
    readWord(0, 9'd5);
    checkOutput("bypassA stored", ifA.dout, expVal);

    // Different addresses in one cycle do not interact
    applyStimulus(0, 1'b0, 1'b1, 9'd8, 32'hFFFF_FFFF, 256'hCAFE, 1'b1, 9'd9);
    checkOutput("diffAddr rd", ifA.dout, 0);
    readWord(0, 9'd8);
    checkOutput("diffAddr wr", ifA.dout, 256'hCAFE);

    // Zero mask writes nothing
    writeWord(0, 9'd9, 256'hFFFF, 32'h0);
    readWord(0, 9'd9);
    checkOutput("zeroMask", ifA.dout, 0);

    // dutB: two-edge latency, back-to-back reads in order
    writeWord(1, 9'd1, 256'h101, 32'hFFFF_FFFF);
    writeWord(1, 9'd2, 256'h202, 32'hFFFF_FFFF);
    writeWord(1, 9'd3, 256'h303, 32'hFFFF_FFFF);
    readWord(1, 9'd1);
    checkOutput("lat2 vld0", ifB.dout_vld, 0);
    readWord(1, 9'd2);
    checkOutput("lat2 vld1", ifB.dout_vld, 1);
    checkOutput("lat2 d1", ifB.dout, 256'h101);
    readWord(1, 9'd3);
    checkOutput("lat2 vld2", ifB.dout_vld, 1);
    checkOutput("lat2 d2", ifB.dout, 256'h202);
    idleCycle();
    checkOutput("lat2 vld3", ifB.dout_vld, 1);
    checkOutput("lat2 d3", ifB.dout, 256'h303);
    idleCycle();
    checkOutput("lat2 vldOff", ifB.dout_vld, 0);
    checkOutput("lat2 hold", ifB.dout, 256'h303);

    // dutB without bypass returns the pre-write content
    applyStimulus(1, 1'b0, 1'b1, 9'd7, 32'hFFFF_FFFF, 256'h1234, 1'b1, 9'd7);
    idleCycle();
    checkOutput("noBypass old", ifB.dout, 0);
    checkOutput("noBypass vld", ifB.dout_vld, 1);
    readWord(1, 9'd7);
    idleCycle();
    checkOutput("noBypass reread", ifB.dout, 256'h1234);

    // Out-of-range write dropped, read returns zero, no alias at 144
    writeWord(1, 9'd400, 256'hDEAD, 32'hFFFF_FFFF);
    readWord(1, 9'd400);
    idleCycle();
    checkOutput("oor rd", ifB.dout, 0);
    checkOutput("oor vld", ifB.dout_vld, 1);
    readWord(1, 9'd144);
    idleCycle();
    checkOutput("oor alias", ifB.dout, 0);
    writeWord(1, 9'd299, 256'h299, 32'hFFFF_FFFF);
    readWord(1, 9'd299);
    idleCycle();
    checkOutput("lastEntry", ifB.dout, 256'h299);
    readWord(1, 9'd300);
    idleCycle();
    checkOutput("firstOor", ifB.dout, 0);
    checkOutput("firstOor vld", ifB.dout_vld, 1);

    // clr with a simultaneous write; traffic during the sweep is dropped
    // and a second clr mid-sweep is ignored
    readWord(0, 9'd8);
    checkOutput("preClr dout", ifA.dout, 256'hCAFE);
    applyStimulus(0, 1'b1, 1'b1, 9'd3, 32'hFFFF_FFFF, 256'hFF, 1'b0, 9'd0);
    checkOutput("clr rdyLow", ifA.rdy, 0);
    n = 0; doneA = 0; edgesA = 0;
    while (n < 700 && !doneA) begin
      if (n + 1 == 50) begin
        applyStimulus(0, 1'b0, 1'b1, 9'd10, 32'hFFFF_FFFF, 256'hBEEF, 1'b1, 9'd3);
        checkOutput("clr dropVld", ifA.dout_vld, 0);
        checkOutput("clr holdDout", ifA.dout, 256'hCAFE);
      end else if (n + 1 == 100) begin
        applyStimulus(0, 1'b1, 1'b0, 9'd0, 32'h0, 256'h0, 1'b0, 9'd0);
      end else begin
        idleCycle();
      end
      n++;
      if (ifA.rdy) begin doneA = 1; edgesA = n; end
    end
    checkOutput("clr edges", 256'(edgesA), 256'd512);
    readWord(0, 9'd3);
    checkOutput("clr addr3", ifA.dout, 0);
    readWord(0, 9'd10);
    checkOutput("clr dropWr", ifA.dout, 0);

    // Reset in the middle of a sweep clears outputs at once and restarts
    writeWord(0, 9'd20, 256'h77, 32'hFFFF_FFFF);
    readWord(0, 9'd20);
    checkOutput("preRst dout", ifA.dout, 256'h77);
    applyStimulus(0, 1'b1, 1'b0, 9'd0, 32'h0, 256'h0, 1'b0, 9'd0);
    for (int i = 0; i < 199; i++) idleCycle();
    checkOutput("midSweep rdy", ifA.rdy, 0);
    checkOutput("midSweep hold", ifA.dout, 256'h77);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("asyncRst rdy", ifA.rdy, 0);
    checkOutput("asyncRst dout", ifA.dout, 0);
    checkOutput("asyncRst vld", ifA.dout_vld, 0);
    @(negedge clk);
    rstn = 1'b1;
    n = 0; doneA = 0; edgesA = 0;
    while (n < 700 && !doneA) begin
      idleCycle();
      n++;
      if (ifA.rdy) begin doneA = 1; edgesA = n; end
    end
    checkOutput("restart edges", 256'(edgesA), 256'd512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
